// File: rtl/mo_linebuf_pkg.sv
// Shared constants and types for the motion-object ping-pong line buffer.
package mo_linebuf_pkg;
    localparam int AW = 8;
    localparam int DW = 4;
    localparam logic [DW-1:0] TRANSPARENT = '0;
    localparam logic [7:0] DROP_MAX = 8'hFF;

    typedef enum logic {WR_IDLE, WR_CHECK} wr_state_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == DROP_MAX) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/mo_linebuf_if.sv
// Pixel handshake from the MO generator and the display read/clear port.
interface mo_linebuf_if;
    import mo_linebuf_pkg::*;

    logic          pix_valid;
    logic          pix_ready;
    logic [AW-1:0] pix_x;
    logic [DW-1:0] pix_color;
    logic          rd_en;
    logic [AW-1:0] rd_x;
    logic [DW-1:0] pix_out;

    modport master (output pix_valid, pix_x, pix_color, rd_en, rd_x,
                    input  pix_ready, pix_out);
    modport slave  (input  pix_valid, pix_x, pix_color, rd_en, rd_x,
                    output pix_ready, pix_out);
endinterface

// File: rtl/mo_linebuf_writer.sv
// Read-check-write of MO pixels into the write buffer, plus collision accounting.
//   state    | meaning
//   WR_IDLE  | ready for a pixel; a transfer issues the read of the old cell
//   WR_CHECK | old cell on RAM data; write if it was empty, else count a drop
module mo_linebuf_writer
    import mo_linebuf_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          line_start,
    input  logic          sel,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic [AW-1:0] pix_x,
    input  logic [DW-1:0] pix_color,
    input  logic [DW-1:0] wr_old,
    output logic          wr_buf,
    output logic          wr_cs,
    output logic          wr_we,
    output logic [AW-1:0] wr_a,
    output logic [DW-1:0] wr_i,
    output logic [7:0]    drop_count
);
    wr_state_e     state_q, state_d;
    logic [AW-1:0] x_q, x_d;
    logic [DW-1:0] color_q, color_d;
    logic          wsel_q, wsel_d;
    logic [7:0]    acc_q, acc_d, acc_next;
    logic [7:0]    drop_q, drop_d;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        color_d   = color_q;
        wsel_d    = wsel_q;
        acc_next  = acc_q;
        pix_ready = 1'b0;
        wr_buf    = sel;
        wr_cs     = 1'b0;
        wr_we     = 1'b0;
        wr_a      = pix_x;
        wr_i      = color_q;
        case (state_q)
            WR_IDLE: begin
                pix_ready = !reset && !line_start;
                if (pix_valid && pix_ready) begin
                    x_d     = pix_x;
                    color_d = pix_color;
                    wsel_d  = sel;
                    wr_cs   = 1'b1;
                    state_d = WR_CHECK;
                end
            end
            WR_CHECK: begin
                // Latched wsel keeps a pixel in flight across a line_start swap.
                wr_buf  = wsel_q;
                wr_a    = x_q;
                state_d = WR_IDLE;
                if (!reset && color_q != TRANSPARENT) begin
                    if (wr_old == TRANSPARENT) wr_we = 1'b1;
                    else                       acc_next = sat_inc(acc_q);
                end
            end
            default: state_d = WR_IDLE;
        endcase
        drop_d = line_start ? acc_next : drop_q;
        acc_d  = line_start ? 8'd0 : acc_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WR_IDLE;
            x_q     <= '0;
            color_q <= '0;
            wsel_q  <= 1'b0;
            acc_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            color_q <= color_d;
            wsel_q  <= wsel_d;
            acc_q   <= acc_d;
            drop_q  <= drop_d;
        end
    end

    assign drop_count = drop_q;
endmodule

// File: rtl/mo_linebuf_ctl.sv
// Ping-pong MO line-buffer controller: buffer select, display read/clear and RAM port muxes.
module mo_linebuf_ctl
    import mo_linebuf_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          line_start,
    mo_linebuf_if.slave   pix_if,
    output logic [7:0]    drop_count,
    output logic [AW-1:0] buf0_a,
    output logic [DW-1:0] buf0_i,
    output logic          buf0_cs_n,
    output logic          buf0_w_n,
    input  logic [DW-1:0] buf0_d,
    output logic [AW-1:0] buf1_a,
    output logic [DW-1:0] buf1_i,
    output logic          buf1_cs_n,
    output logic          buf1_w_n,
    input  logic [DW-1:0] buf1_d
);
    logic          sel_q, sel_d;
    logic          seld_q, seld_d;
    logic          rd_en_q, rd_en_d;
    logic          rd_act;
    logic          wr_buf, wr_cs, wr_we;
    logic [AW-1:0] wr_a;
    logic [DW-1:0] wr_i, wr_old;

    assign wr_old = wr_buf ? buf1_d : buf0_d;

    mo_linebuf_writer u_writer (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .sel        (sel_q),
        .pix_valid  (pix_if.pix_valid),
        .pix_ready  (pix_if.pix_ready),
        .pix_x      (pix_if.pix_x),
        .pix_color  (pix_if.pix_color),
        .wr_old     (wr_old),
        .wr_buf     (wr_buf),
        .wr_cs      (wr_cs),
        .wr_we      (wr_we),
        .wr_a       (wr_a),
        .wr_i       (wr_i),
        .drop_count (drop_count)
    );

    always_comb begin
        rd_act  = pix_if.rd_en && !reset;
        sel_d   = line_start ? !sel_q : sel_q;
        seld_d  = !sel_q;
        rd_en_d = rd_act;

        // Display side owns buffer !sel; reading also clears the cell on the same edge.
        buf0_a    = pix_if.rd_x;
        buf0_i    = TRANSPARENT;
        buf0_cs_n = !(rd_act && sel_q);
        buf0_w_n  = !(rd_act && sel_q);
        buf1_a    = pix_if.rd_x;
        buf1_i    = TRANSPARENT;
        buf1_cs_n = !(rd_act && !sel_q);
        buf1_w_n  = !(rd_act && !sel_q);

        if (!wr_buf) begin
            buf0_a    = wr_a;
            buf0_i    = wr_i;
            buf0_cs_n = !wr_cs;
            buf0_w_n  = !wr_we;
        end else begin
            buf1_a    = wr_a;
            buf1_i    = wr_i;
            buf1_cs_n = !wr_cs;
            buf1_w_n  = !wr_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q   <= 1'b0;
            seld_q  <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            seld_q  <= seld_d;
            rd_en_q <= rd_en_d;
        end
    end

    assign pix_if.pix_out = (!reset && rd_en_q) ? (seld_q ? buf1_d : buf0_d) : '0;
endmodule

// File: tb/tb_mo_linebuf_ctl.sv
// Bench for mo_linebuf_ctl: two RAM models, a line-level buffer model and directed + random stimulus.
module tb_mo_linebuf_ctl;
    import mo_linebuf_pkg::*;

    logic clk, reset, line_start;
    logic [7:0] drop_count;
    logic [7:0] buf0_a, buf1_a;
    logic [3:0] buf0_i, buf1_i, buf0_d, buf1_d;
    logic buf0_cs_n, buf0_w_n, buf1_cs_n, buf1_w_n;

    mo_linebuf_if ifc();

    mo_linebuf_ctl dut (
        .clk(clk), .reset(reset), .line_start(line_start), .pix_if(ifc),
        .drop_count(drop_count),
        .buf0_a(buf0_a), .buf0_i(buf0_i), .buf0_cs_n(buf0_cs_n), .buf0_w_n(buf0_w_n), .buf0_d(buf0_d),
        .buf1_a(buf1_a), .buf1_i(buf1_i), .buf1_cs_n(buf1_cs_n), .buf1_w_n(buf1_w_n), .buf1_d(buf1_d)
    );

    // External RAMs: registered read data, write independent of cs_n, read-before-write.
    logic [3:0] ram0 [256];
    logic [3:0] ram1 [256];
    always @(posedge clk) begin
        if (!buf0_cs_n) buf0_d <= ram0[buf0_a];
        if (!buf0_w_n)  ram0[buf0_a] <= buf0_i;
        if (!buf1_cs_n) buf1_d <= ram1[buf1_a];
        if (!buf1_w_n)  ram1[buf1_a] <= buf1_i;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Line-level model: contents of each buffer as the display will see them.
    logic [3:0] mem [2][256];
    bit   m_sel, m_busy, p_buf;
    logic [7:0] p_x;
    logic [3:0] p_c;
    int   m_acc, m_drop;
    bit   exp_ready;
    logic [3:0] exp_pix;
    bit   chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pix_ready", ifc.pix_ready, exp_ready);
            chk("pix_out", ifc.pix_out, reset ? 4'd0 : exp_pix);
            chk("drop_count", drop_count, m_drop);
            if (reset) chk("rst_strobes", {buf0_cs_n, buf0_w_n, buf1_cs_n, buf1_w_n}, 4'hF);
        end
    end

    task automatic step(input bit r, input bit ls, input bit v, input logic [7:0] x,
                        input logic [3:0] c, input bit re, input logic [7:0] rx);
        bit xfer;
        logic [3:0] np;
        reset = r; line_start = ls;
        ifc.pix_valid = v; ifc.pix_x = x; ifc.pix_color = c;
        ifc.rd_en = re; ifc.rd_x = rx;
        exp_ready = !r && !ls && !m_busy;
        @(posedge clk);
        xfer = v && exp_ready;
        np = 4'd0;
        if (!r && re) begin
            np = mem[!m_sel][rx];
            mem[!m_sel][rx] = 4'd0;
        end
        // First-drawn object wins; an opaque pixel over an opaque one is a drop.
        if (m_busy && !r && p_c != 4'd0) begin
            if (mem[p_buf][p_x] == 4'd0) mem[p_buf][p_x] = p_c;
            else if (m_acc < 255) m_acc++;
        end
        if (r) begin
            m_sel = 0; m_acc = 0; m_drop = 0; m_busy = 0;
        end else begin
            if (ls) begin
                m_drop = m_acc; m_acc = 0; m_sel = !m_sel;
            end
            m_busy = xfer;
            if (xfer) begin
                p_x = x; p_c = c; p_buf = m_sel;
            end
        end
        exp_pix = np;
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 8'd0, 4'd0, 0, 8'd0);
    endtask

    task automatic wr(input logic [7:0] x, input logic [3:0] c);
        step(0, 0, 1, x, c, 0, 8'd0);
        idle();
    endtask

    task automatic rd(input logic [7:0] x);
        step(0, 0, 0, 8'd0, 4'd0, 1, x);
    endtask

    task automatic ls_pulse();
        step(0, 1, 0, 8'd0, 4'd0, 0, 8'd0);
    endtask

    int n_x;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram0[i] = 4'd0; ram1[i] = 4'd0;
            mem[0][i] = 4'd0; mem[1][i] = 4'd0;
        end
        m_sel = 0; m_busy = 0; m_acc = 0; m_drop = 0; exp_pix = 0; exp_ready = 0;
        p_buf = 0; p_x = 0; p_c = 0;
        reset = 1; line_start = 0;
        ifc.pix_valid = 0; ifc.pix_x = 0; ifc.pix_color = 0; ifc.rd_en = 0; ifc.rd_x = 0;
        @(posedge clk); #1;
        chk_en = 1;

        // Reset held for 3 clocks, then ready on release.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 8'd10, 4'd5, 1, 8'd10);
        chk("rst_drop", drop_count, 8'd0);
        chk("rst_pix_out", ifc.pix_out, 4'd0);
        reset = 0; ifc.pix_valid = 0; ifc.rd_en = 0;
        #1 chk("ready_release", ifc.pix_ready, 1'b1);

        // Single pixel, swap, read back then cleared.
        wr(8'd10, 4'd5);
        ls_pulse();
        rd(8'd10);
        chk("px10", ifc.pix_out, 4'd5);
        rd(8'd10);
        chk("px10_clr", ifc.pix_out, 4'd0);

        // Collision: first-drawn colour stays, one drop.
        wr(8'd20, 4'd3);
        wr(8'd20, 4'd7);
        ls_pulse();
        chk("drop1", drop_count, 8'd1);
        rd(8'd20);
        chk("px20", ifc.pix_out, 4'd3);

        // Transparent pixel and top address.
        wr(8'd30, 4'd0);
        wr(8'd255, 4'd9);
        ls_pulse();
        chk("drop0", drop_count, 8'd0);
        rd(8'd30);
        chk("px30", ifc.pix_out, 4'd0);
        rd(8'd255);
        chk("px255", ifc.pix_out, 4'd9);

        // line_start in the CHECK cycle.
        step(0, 0, 1, 8'd50, 4'd6, 0, 8'd0);
        line_start = 1; ifc.pix_valid = 1; ifc.pix_x = 8'd51; ifc.pix_color = 4'd4;
        #1 chk("ready_in_ls", ifc.pix_ready, 1'b0);
        step(0, 1, 1, 8'd51, 4'd4, 0, 8'd0);
        rd(8'd50);
        chk("px50", ifc.pix_out, 4'd6);
        rd(8'd51);
        chk("px51", ifc.pix_out, 4'd0);

        // 300 collisions back-to-back: saturation and 2-clock throughput.
        wr(8'd40, 4'd1);
        n_x = 0;
        for (int i = 0; i < 600; i++) begin
            step(0, 0, 1, 8'd40, 4'd2, 0, 8'd0);
            if (exp_ready) n_x++;
        end
        chk("throughput", n_x, 300);
        idle();
        ls_pulse();
        chk("drop_sat", drop_count, 8'd255);
        rd(8'd40);
        chk("px40", ifc.pix_out, 4'd1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bit r, ls, v, re;
            logic [7:0] x, rx;
            logic [3:0] c;
            r  = ($urandom_range(0, 499) == 0);
            ls = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 2) != 0);
            x  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            c  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            re = ($urandom_range(0, 1) == 1);
            rx = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            step(r, ls, v, x, c, re, rx);
        end
        idle();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
